// File: rtl/mem_wr.sv
// Frame-buffer writer: drains BRAM_DEPTH pixels from the upstream FIFO into
// BRAM addresses 0..BRAM_DEPTH-1, then raises o_done and o_req for the reader.
module mem_wr #(
    parameter  int BRAM_DEPTH = 16384,
    parameter  int DATA_W     = 12,
    parameter  int REQ_CYCLES = 4,
    localparam int ADDR_W     = $clog2(BRAM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic              i_empty,
    output logic              o_rd,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_req
);

    localparam int REQ_W = $clog2(REQ_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    state_t            state;
    logic              q1;
    logic              sync;
    logic              sync_d;
    logic              start_edge;
    logic              rd_valid;
    logic [ADDR_W:0]   rcnt;
    logic [ADDR_W-1:0] wcnt;
    logic [REQ_W-1:0]  reqcnt;

    assign start_edge = sync & ~sync_d;
    assign o_busy     = (state != IDLE);
    assign o_rd       = (state == ACTIVE) && !i_empty
                      && (rcnt < (ADDR_W+1)'(BRAM_DEPTH));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state    <= IDLE;
            q1       <= 1'b0;
            sync     <= 1'b0;
            sync_d   <= 1'b0;
            rd_valid <= 1'b0;
            rcnt     <= '0;
            wcnt     <= '0;
            reqcnt   <= '0;
            o_wr     <= 1'b0;
            o_waddr  <= '0;
            o_wdata  <= '0;
            o_done   <= 1'b0;
            o_req    <= 1'b0;
        end else begin
            q1       <= i_start;
            sync     <= q1;
            sync_d   <= sync;
            rd_valid <= o_rd;
            o_wr     <= 1'b0;
            o_done   <= 1'b0;
            case (state)
                IDLE: begin
                    rcnt   <= '0;
                    wcnt   <= '0;
                    reqcnt <= '0;
                    o_req  <= 1'b0;
                    if (start_edge)
                        state <= ACTIVE;
                end
                ACTIVE: begin
                    if (o_rd)
                        rcnt <= rcnt + 1'b1;
                    // FIFO data arrives one cycle after the strobe
                    if (rd_valid) begin
                        o_wr    <= 1'b1;
                        o_wdata <= i_rdata;
                        o_waddr <= wcnt;
                        wcnt    <= wcnt + 1'b1;
                        if (wcnt == ADDR_W'(BRAM_DEPTH - 1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (reqcnt == REQ_W'(REQ_CYCLES)) begin
                        o_req  <= 1'b0;
                        reqcnt <= '0;
                        state  <= IDLE;
                    end else begin
                        o_req  <= 1'b1;
                        o_done <= (reqcnt == '0);
                        reqcnt <= reqcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wr.sv
// Bench for mem_wr: frame scenarios from a table plus hand-written
// sequences for ignored restarts and mid-frame reset.
module tb_mem_wr;

    logic        i_clk;
    logic        i_rstn;
    logic        i_start;
    logic        i_empty;
    logic        o_rd;
    logic [11:0] i_rdata;
    logic        o_wr;
    logic [3:0]  o_waddr;
    logic [11:0] o_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_req;

    mem_wr #(
        .BRAM_DEPTH(16),
        .DATA_W    (12),
        .REQ_CYCLES(4)
    ) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_start(i_start),
        .i_empty(i_empty),
        .o_rd   (o_rd),
        .i_rdata(i_rdata),
        .o_wr   (o_wr),
        .o_waddr(o_waddr),
        .o_wdata(o_wdata),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_req  (o_req)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic stall;
        logic b2b;
        int   exp_wr;
        int   exp_done;
        int   exp_req;
        int   exp_run;
    } vec_t;

    vec_t tbl [3];

    int total = 0;
    int bad   = 0;
    int n_wr = 0, n_rd = 0, n_done = 0, n_req = 0;
    int s_wr, s_rd, s_done, s_req;
    int exp_addr = 0;
    int rd_run = 0, max_run = 0;
    int cyc = 0;
    int fifo_ptr = 'h100;
    int ed;
    int busy_cnt;
    int exp_q [$];
    logic rd_n = 1'b0;
    logic stall_en = 1'b0;
    logic prev_w15 = 1'b0;
    logic prev_req = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"},    int'(o_rd),    0);
        chk({tag, "_wr"},    int'(o_wr),    0);
        chk({tag, "_waddr"}, int'(o_waddr), 0);
        chk({tag, "_wdata"}, int'(o_wdata), 0);
        chk({tag, "_busy"},  int'(o_busy),  0);
        chk({tag, "_done"},  int'(o_done),  0);
        chk({tag, "_req"},   int'(o_req),   0);
    endtask

    task automatic start_frame(input logic hold);
        max_run  = 0;
        rd_run   = 0;
        exp_addr = 0;
        s_wr     = n_wr;
        s_rd     = n_rd;
        s_done   = n_done;
        s_req    = n_req;
        @(posedge i_clk);
        #1 i_start = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("busy_k1", int'(o_busy), 0);
        @(negedge i_clk);
        chk("busy_k2", int'(o_busy), 1);
        if (!hold) begin
            @(posedge i_clk);
            #1 i_start = 1'b0;
        end
    endtask

    task automatic wait_wr(input int a);
        int t;
        t = 0;
        do begin
            @(negedge i_clk);
            t++;
        end while (!(o_wr && int'(o_waddr) == a) && t < 100);
        chk("wait_wr", int'(o_wr && int'(o_waddr) == a), 1);
    endtask

    task automatic end_frame(input int ewr, input int edn,
                             input int erq, input int erun);
        int t;
        t = 0;
        do begin
            @(negedge i_clk);
            t++;
        end while (o_busy && t < 400);
        chk("idle_timeout", int'(o_busy), 0);
        chk("n_wr",   n_wr - s_wr,     ewr);
        chk("n_rd",   n_rd - s_rd,     ewr);
        chk("n_done", n_done - s_done, edn);
        chk("n_req",  n_req - s_req,   erq);
        chk("last_addr", exp_addr, ewr);
        chk("leftover", exp_q.size(), 0);
        if (erun > 0)
            chk("rd_run", max_run, erun);
    endtask

    initial begin
        tbl[0] = '{stall: 1'b0, b2b: 1'b0, exp_wr: 16, exp_done: 1,
                   exp_req: 4, exp_run: 16};
        tbl[1] = '{stall: 1'b1, b2b: 1'b0, exp_wr: 16, exp_done: 1,
                   exp_req: 4, exp_run: 2};
        tbl[2] = '{stall: 1'b0, b2b: 1'b1, exp_wr: 16, exp_done: 1,
                   exp_req: 4, exp_run: 16};
        i_rstn  = 1'b0;
        i_start = 1'b0;
        i_empty = 1'b0;
        i_rdata = '0;
        fork
            forever begin
                // monitor: outputs sampled on the falling edge
                @(negedge i_clk);
                rd_n = o_rd;
                if (o_rd) begin
                    n_rd++;
                    rd_run++;
                    if (rd_run > max_run)
                        max_run = rd_run;
                end else begin
                    rd_run = 0;
                end
                if (o_wr) begin
                    chk("waddr", int'(o_waddr), exp_addr);
                    ed = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    chk("wdata", int'(o_wdata), ed);
                    exp_addr++;
                    n_wr++;
                end
                if (o_done) begin
                    n_done++;
                    chk("done_pos", int'({prev_w15, o_wr}), 2);
                end
                if (o_req) begin
                    n_req++;
                    chk("req_no_wr", int'(o_wr), 0);
                end
                if (prev_req && !o_req)
                    chk("req_fall_busy", int'(o_busy), 0);
                prev_w15 = o_wr && (o_waddr == 4'd15);
                prev_req = o_req;
                // FIFO model: pop on a strobe, data valid one cycle later
                @(posedge i_clk);
                #1;
                cyc++;
                i_empty = stall_en & cyc[1];
                if (rd_n) begin
                    i_rdata = fifo_ptr[11:0];
                    exp_q.push_back(int'(fifo_ptr[11:0]));
                    fifo_ptr++;
                end
            end
            begin
                repeat (3) @(posedge i_clk);
                @(negedge i_clk);
                chk_zero("reset");
                @(posedge i_clk);
                #1 i_rstn = 1'b1;

                for (int i = 0; i < 3; i++) begin
                    stall_en = tbl[i].stall;
                    if (!tbl[i].b2b)
                        repeat (5) @(posedge i_clk);
                    start_frame(1'b0);
                    end_frame(tbl[i].exp_wr, tbl[i].exp_done,
                              tbl[i].exp_req, tbl[i].exp_run);
                end

                // restart attempts mid-frame, then start held high
                stall_en = 1'b0;
                repeat (5) @(posedge i_clk);
                start_frame(1'b0);
                wait_wr(5);
                @(posedge i_clk);
                #1 i_start = 1'b1;
                repeat (2) @(posedge i_clk);
                #1 i_start = 1'b0;
                repeat (2) @(posedge i_clk);
                #1 i_start = 1'b1;
                end_frame(16, 1, 4, 16);
                busy_cnt = 0;
                repeat (10) begin
                    @(negedge i_clk);
                    busy_cnt += int'(o_busy);
                end
                chk("no_retrigger", busy_cnt, 0);
                @(posedge i_clk);
                #1 i_start = 1'b0;

                // reset mid-frame, then a clean frame from address 0
                repeat (5) @(posedge i_clk);
                start_frame(1'b0);
                wait_wr(7);
                i_rstn = 1'b0;
                @(posedge i_clk);
                #3;
                exp_q.delete();
                i_rstn = 1'b1;
                @(negedge i_clk);
                chk_zero("midrst");
                repeat (3) @(posedge i_clk);
                start_frame(1'b0);
                end_frame(16, 1, 4, 16);
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
